fminmax_arbiter: RTL and testbench
==================================

// Module: fminmax_arbiter
// PURPOSE
//  Shares one FMIN/FMAX datapath (the team's combinational fmin unit plus an equivalent max
//  path) between two requesters: port 0 = pipeline FPU issue, port 1 = ISS/debug port.
//  Round-robin arbitration, valid/ready request and response handshakes, registered result.
//  Accumulates a sticky invalid-operation (NV) flag for the FP CSR (fflags).
// PARAMETERS
//  WIDTH  32  operand/result width (single-precision only; other values unsupported)
//  TAG_W  5   width of the opaque request tag (e.g. rd index) returned with the result
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  flush      in   1          sync abort of in-flight op (pipeline redirect)
//  req_valid  in   2          per-port request valid
//  req_ready  out  2          per-port accept; a transfer occurs when valid&ready on that port
//  req_a      in   2*WIDTH    operand a; port p = [p*WIDTH +: WIDTH]
//  req_b      in   2*WIDTH    operand b; same packing
//  req_op     in   2          per-port op: 0 = FMIN.S, 1 = FMAX.S
//  req_tag    in   2*TAG_W    per-port tag
//  rsp_valid  out  2          one-hot: result valid for that port
//  rsp_ready  in   2          per-port response accept
//  rsp_data   out  WIDTH      result
//  rsp_tag    out  TAG_W      tag of the completed op
//  rsp_nv     out  1          NV for this op (sNaN on either input)
//  fflags_nv  out  1          sticky NV accumulator
//  flags_clr  in   1          clear fflags_nv
// BEHAVIOUR
//  FSM IDLE -> EXEC -> RESP -> IDLE. Reset: state = IDLE, rr_last = 1 (port 0 wins first tie),
//   rsp_valid = 0, rsp_data = 0, rsp_tag = 0, rsp_nv = 0, fflags_nv = 0.
//  IDLE: req_ready = one-hot grant; grant = the only valid port, or, if both are valid, the port
//   != rr_last. On transfer: latch a, b, op, tag and port; rr_last <= port; -> EXEC.
//   req_ready = 0 in every other state.
//  EXEC: one cycle; result computed from the latched operands and registered; -> RESP.
//  RESP: rsp_valid[port] = 1; data/tag/nv held stable until rsp_ready[port] = 1, then -> IDLE.
//   rsp_ready of the non-owning port is ignored.
//  Latency: request accepted in cycle N -> rsp_valid high in cycle N+2. Peak throughput:
//   1 op per 3 cycles (no IDLE bypass).
//  MIN: identical to the team fmin rules:
//   - exactly one NaN -> the other operand; both NaN -> 0x7FC00000
//   - NV = any sNaN (exp = FF, frac != 0, frac[22] = 0)
//   - min(+0,-0) = -0 in either order
//   - otherwise numeric order; equal values return a
//  MAX: the same rules, with the order inverted and max(+0,-0) = +0.
//  fflags_nv: set in the cycle EXEC->RESP if NV = 1; flags_clr clears it. A simultaneous set
//   and clear -> 1 (set wins).
//  flush: next state IDLE from any state; a pending result is dropped (rsp_valid low the next
//   cycle); fflags_nv is not updated by the aborted op if flush is seen in EXEC. rr_last is
//   kept. A request offered in the same cycle as flush is not accepted.
//  Async reset mid-operation: immediate return to the reset values; the op is lost.
//  req_valid may drop without a transfer; no request state is held while IDLE.
// TESTING
//  T1 port0 MIN a=3F800000 b=40000000 -> N+2 rsp_valid=01, data=3F800000, nv=0; MAX -> 40000000
//  T2 both valid from reset, 4 back-to-back ops -> grants 0,1,0,1; req_ready never 11
//  T3 MIN a=7F800001(sNaN) b=BF800000 -> data=BF800000, rsp_nv=1, fflags_nv=1 until flags_clr
//  T4 MIN(00000000,80000000) -> 80000000; MAX(80000000,00000000) -> 00000000; MIN(qNaN,qNaN) -> 7FC00000, nv=0
//  T5 hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=00; rsp_ready on wrong port ignored
//  T6 flush in EXEC with sNaN op -> no rsp_valid, fflags_nv stays 0; rst_n low in RESP -> all outputs 0

Source files
------------

// File: rtl/fminmax_arbiter.sv
// fminmax_arbiter: round-robin shared FMIN.S/FMAX.S unit for two requesters
// with a registered result, response handshake and sticky NV flag.
module fminmax_arbiter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [1:0]         req_op,
  input  logic [2*TAG_W-1:0] req_tag,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_nv,
  output logic               fflags_nv,
  input  logic               flags_clr
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;
  state_e state_q, state_d;
  logic rr_q, port_q, op_q, nv_q, ff_q, ff_d, gnt, take, exec, a_nan, b_nan, zz, nv_w, a_lt, b_lt;
  logic [WIDTH-1:0] a_q, b_q, data_q, res_w;
  logic [TAG_W-1:0] tag_q;
  function automatic logic is_nan(input logic [WIDTH-1:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction
  // Numeric less-than for non-NaN operands that are not both zero
  function automatic logic lt(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    return (x[31] != y[31]) ? x[31] : (x[31] ? x[30:0] > y[30:0] : x[30:0] < y[30:0]);
  endfunction
  always_comb begin
    gnt = (&req_valid) ? ~rr_q : req_valid[1];
    take = (state_q == IDLE) && (|req_valid) && !flush;
    exec = (state_q == EXEC) && !flush;
    req_ready = take ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = (state_q == RESP) ? (port_q ? 2'b10 : 2'b01) : 2'b00;
    state_d = flush ? IDLE :
              take ? EXEC :
              (state_q == EXEC) ? RESP :
              (state_q == RESP && rsp_ready[port_q]) ? IDLE : state_q;
    a_nan = is_nan(a_q);
    b_nan = is_nan(b_q);
    nv_w = (a_nan && !a_q[22]) || (b_nan && !b_q[22]);
    zz = ~|a_q[30:0] && ~|b_q[30:0];
    a_lt = lt(a_q, b_q);
    b_lt = lt(b_q, a_q);
    res_w = (a_nan && b_nan) ? 32'h7FC0_0000 :
            a_nan ? b_q :
            b_nan ? a_q :
            zz ? {op_q ? (a_q[31] & b_q[31]) : (a_q[31] | b_q[31]), 31'b0} :
            (op_q ? b_lt : a_lt) ? a_q : b_q;
    ff_d = (exec && nv_w) || (ff_q && !flags_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 1'b1;
      port_q <= 1'b0;
      op_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      data_q <= '0;
      nv_q <= 1'b0;
      ff_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ff_q <= ff_d;
      if (take) begin
        rr_q <= gnt;
        port_q <= gnt;
        op_q <= req_op[gnt];
        a_q <= gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
        b_q <= gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
        tag_q <= gnt ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
      end
      if (exec) begin
        data_q <= res_w;
        nv_q <= nv_w;
      end
    end
  end
  assign rsp_data = data_q;
  assign rsp_tag = tag_q;
  assign rsp_nv = nv_q;
  assign fflags_nv = ff_q;
endmodule

// File: tb/tb_fminmax_arbiter.sv
// tb_fminmax_arbiter: directed checks of arbitration, handshakes, min/max
// results, NV flag, flush and async reset.
module tb_fminmax_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, flags_clr = 1'b0;
  logic [1:0] req_valid = '0, req_ready, req_op = '0, rsp_valid, rsp_ready = '0;
  logic [63:0] req_a = '0, req_b = '0;
  logic [9:0] req_tag = '0;
  logic [31:0] rsp_data;
  logic [4:0] rsp_tag;
  logic rsp_nv, fflags_nv;
  int checks = 0, errs = 0, both_rdy = 0;
  fminmax_arbiter dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_nv(rsp_nv),
    .fflags_nv(fflags_nv), .flags_clr(flags_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (req_ready == 2'b11) both_rdy++;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_port(input int p, input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    req_op[p] = op;
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
    req_tag[p*5 +: 5] = tag;
  endtask
  task automatic do_op(input string nm, input int p, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] ed, input logic env, input logic eff);
    logic [1:0] oh;
    oh = 2'(1 << p);
    set_port(p, op, a, b, tag);
    req_valid = oh;
    #1 chk({nm, "_rdy"}, req_ready, oh);
    @(posedge clk); #1;
    req_valid = '0;
    chk({nm, "_exec"}, rsp_valid, 2'b00);
    @(posedge clk); #1;
    chk({nm, "_vld"}, rsp_valid, oh);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_nv"}, rsp_nv, env);
    chk({nm, "_tag"}, rsp_tag, tag);
    chk({nm, "_ff"}, fflags_nv, eff);
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = '0;
    chk({nm, "_done"}, rsp_valid, 2'b00);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", rsp_valid, 2'b00);
    chk("rst_data", rsp_data, 0);
    chk("rst_tag", rsp_tag, 0);
    chk("rst_nv", {rsp_nv, fflags_nv}, 2'b00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    // T2: contention from reset alternates grants starting with port 0
    set_port(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd10);
    set_port(1, 1'b1, 32'h3F80_0000, 32'h4000_0000, 5'd11);
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] e;
      e = (k % 2) ? 2'b10 : 2'b01;
      #1 chk("t2_grant", req_ready, e);
      @(posedge clk); #1;
      chk("t2_exec_rdy", req_ready, 2'b00);
      @(posedge clk); #1;
      chk("t2_vld", rsp_valid, e);
      chk("t2_tag", rsp_tag, (k % 2) ? 5'd11 : 5'd10);
      chk("t2_data", rsp_data, (k % 2) ? 32'h4000_0000 : 32'h3F80_0000);
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    rsp_ready = '0;
    chk("t2_never_11", both_rdy, 0);
    @(posedge clk); #1;
    // T1 and T4 plus assorted ordering / NaN cases
    do_op("t1_min", 0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd1, 32'h3F80_0000, 1'b0, 1'b0);
    do_op("t1_max", 0, 1'b1, 32'h3F80_0000, 32'h4000_0000, 5'd2, 32'h4000_0000, 1'b0, 1'b0);
    do_op("t4_minz", 0, 1'b0, 32'h0000_0000, 32'h8000_0000, 5'd3, 32'h8000_0000, 1'b0, 1'b0);
    do_op("t4_maxz", 1, 1'b1, 32'h8000_0000, 32'h0000_0000, 5'd4, 32'h0000_0000, 1'b0, 1'b0);
    do_op("t4_qnan2", 0, 1'b0, 32'h7FC0_0000, 32'h7FC0_0000, 5'd5, 32'h7FC0_0000, 1'b0, 1'b0);
    do_op("qnan_one", 1, 1'b0, 32'h7FC0_0000, 32'h4040_0000, 5'd6, 32'h4040_0000, 1'b0, 1'b0);
    do_op("max_neg", 0, 1'b1, 32'hC000_0000, 32'hBF80_0000, 5'd7, 32'hBF80_0000, 1'b0, 1'b0);
    do_op("min_mix", 1, 1'b0, 32'h3F80_0000, 32'hC000_0000, 5'd8, 32'hC000_0000, 1'b0, 1'b0);
    do_op("min_negz", 0, 1'b0, 32'h8000_0000, 32'h0000_0000, 5'd9, 32'h8000_0000, 1'b0, 1'b0);
    // T3: sNaN raises NV and the sticky flag until cleared
    do_op("t3_snan", 0, 1'b0, 32'h7F80_0001, 32'hBF80_0000, 5'd3, 32'hBF80_0000, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("t3_sticky", fflags_nv, 1'b1);
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    chk("t3_clr", fflags_nv, 1'b0);
    flags_clr = 1'b1;
    do_op("t3_setclr", 1, 1'b1, 32'h4000_0000, 32'h7F80_0001, 5'd4, 32'h4000_0000, 1'b1, 1'b1);
    flags_clr = 1'b0;
    chk("t3_clr2", fflags_nv, 1'b0);
    // T5: response backpressure, wrong-port rsp_ready ignored
    set_port(1, 1'b1, 32'hC000_0000, 32'hBF80_0000, 5'd9);
    req_valid = 2'b10;
    #1 chk("t5_rdy", req_ready, 2'b10);
    @(posedge clk); #1;
    set_port(0, 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd1);
    req_valid = 2'b01;
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("t5_vld", rsp_valid, 2'b10);
      chk("t5_data", rsp_data, 32'hBF80_0000);
      chk("t5_tag", rsp_tag, 5'd9);
      chk("t5_rdy0", req_ready, 2'b00);
      @(posedge clk); #1;
    end
    chk("t5_vld_end", rsp_valid, 2'b10);
    rsp_ready = 2'b10;
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("t5_release", req_ready, 2'b01);
    req_valid = '0;
    @(posedge clk); #1;
    // T6: flush in EXEC with sNaN drops the op and leaves NV untouched
    set_port(0, 1'b0, 32'h7F80_0001, 32'h3F80_0000, 5'd2);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_flush_vld", rsp_valid, 2'b00);
    chk("t6_flush_ff", fflags_nv, 1'b0);
    @(posedge clk); #1;
    chk("t6_flush_vld2", rsp_valid, 2'b00);
    chk("t6_flush_ff2", fflags_nv, 1'b0);
    req_valid = 2'b01;
    flush = 1'b1;
    #1 chk("t6_flush_idle_rdy", req_ready, 2'b00);
    @(posedge clk); #1;
    flush = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;
    chk("t6_not_taken", rsp_valid, 2'b00);
    set_port(1, 1'b0, 32'h3F80_0000, 32'h4000_0000, 5'd6);
    req_valid = 2'b10;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("t6_resp_vld", rsp_valid, 2'b10);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("t6_resp_flush", rsp_valid, 2'b00);
    req_valid = 2'b11;
    #1 chk("t6_rr_kept", req_ready, 2'b01);
    req_valid = '0;
    @(posedge clk); #1;
    // T6: async reset while a result is pending
    set_port(0, 1'b0, 32'h7F80_0001, 32'hC000_0000, 5'h1F);
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("t6_pre_vld", rsp_valid, 2'b01);
    chk("t6_pre_data", rsp_data, 32'hC000_0000);
    chk("t6_pre_ff", {rsp_nv, fflags_nv}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", rsp_valid, 2'b00);
    chk("t6_rst_data", rsp_data, 0);
    chk("t6_rst_tag", rsp_tag, 0);
    chk("t6_rst_nv", {rsp_nv, fflags_nv}, 2'b00);
    chk("t6_rst_rdy", req_ready, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
